// File: rtl/fib_bcd_serializer.sv
// Purpose : converts one binary Fibonacci term to BCD (shift-add-3, one bit per
//           clock) and streams its decimal digits out most-significant first.
// Latency : first digit valid WIDTH clocks after the accepting edge.
// Backpr. : digits hold while out_ready=0; no new term accepted until the
//           units digit has been handed off (in_ready only in IDLE).
// Ports   : clk/rst (async active-high); in_valid/in_ready/in_data term input;
//           out_valid/out_ready/out_digit/out_last digit stream; busy = not IDLE.
module fib_bcd_serializer #(
   parameter int WIDTH         = 16,
   parameter int DIGITS        = 5,
   parameter int BLANK_LEADING = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_digit,
   output logic             out_last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [BW-1:0]    bcd_adj;
   logic [BW-1:0]    bcd_shift;
   logic [IW-1:0]    idx_top;
   logic [3:0]       cur_digit;

   // One double-dabble step: correct every digit >= 5, then shift the next
   // binary bit in. The first digit to emit is chosen from the shifted value so
   // it is ready on the same edge that leaves CONVERT.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                        : bcd_q[4*i +: 4];
      end
      bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

      idx_top = '0;
      if (BLANK_LEADING == 0) begin
         idx_top = IW'(DIGITS - 1);
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) idx_top = IW'(i);
         end
      end
   end

   assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_d   = in_data;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            bcd_d = bcd_shift;
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = EMIT;
               idx_d   = idx_top;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_q == '0) state_d = IDLE;
               else             idx_d   = idx_q - IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs come only from registers (plus rst), so there is no
   // combinational path from in_valid to out_* or from out_ready to in_ready.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == EMIT);
   assign out_digit = out_valid ? cur_digit : 4'd0;
   assign out_last  = out_valid && (idx_q == '0);

endmodule

// File: tb/tb_fib_bcd_serializer.sv
module tb_fib_bcd_serializer;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
   logic [15:0] in_data0 = '0, in_data1 = '0;
   logic        out_ready0 = 1'b1, out_ready1 = 1'b1;
   logic        in_ready0, in_ready1, out_valid0, out_valid1;
   logic        out_last0, out_last1, busy0, busy1;
   logic [3:0]  out_digit0, out_digit1;

   fib_bcd_serializer #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_digit(out_digit0), .out_last(out_last0), .busy(busy0));

   fib_bcd_serializer #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_digit(out_digit1), .out_last(out_last1), .busy(busy1));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: held by main process
   bit start1 = 0, done1 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: decimal digits by repeated division; returns {count, 5 digits}.
   function automatic logic [23:0] model_enc(int v, bit blank);
      logic [19:0] d = '0;
      int n = 1;
      int x = v;
      for (int i = 0; i < 5; i++) begin
         d[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      if (!blank) n = 5;
      else for (int i = 0; i < 5; i++) if (d[4*i +: 4] != 4'd0) n = i + 1;
      return {4'(n), d};
   endfunction

   // Expected digit stream per DUT (circular buffers).
   logic [3:0] qd [2][512];
   bit         ql [2][512];
   int         head [2] = '{0, 0};
   int         tail [2] = '{0, 0};
   int         exp_rise [2] = '{-1, -1};
   bit         last_hs [2] = '{0, 0};
   bit         prev_ov [2] = '{0, 0};

   task automatic push(int k, int v);
      logic [23:0] e;
      int n;
      e = model_enc(v, (k == 0));
      n = int'(e[23:20]);
      for (int i = n - 1; i >= 0; i--) begin
         qd[k][tail[k] % 512] = e[4*i +: 4];
         ql[k][tail[k] % 512] = (i == 0);
         tail[k]++;
      end
   endtask

   // Compare process: all DUT outputs checked on every falling edge.
   bit c_iv, c_ir, c_ov, c_or, c_ol, c_bz;
   logic [3:0] c_od;
   logic [15:0] c_id;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            c_iv = in_valid0; c_ir = in_ready0; c_ov = out_valid0; c_or = out_ready0;
            c_ol = out_last0; c_bz = busy0; c_od = out_digit0; c_id = in_data0;
         end else begin
            c_iv = in_valid1; c_ir = in_ready1; c_ov = out_valid1; c_or = out_ready1;
            c_ol = out_last1; c_bz = busy1; c_od = out_digit1; c_id = in_data1;
         end
         if (rst) begin
            chk($sformatf("reset_in_ready%0d", k), int'(c_ir), 0);
            chk($sformatf("reset_outs%0d", k), int'({c_ov, c_od, c_ol, c_bz}), 0);
            head[k] = tail[k];
            exp_rise[k] = -1;
            last_hs[k] = 0;
            prev_ov[k] = 0;
         end else begin
            chk($sformatf("ready_vs_busy%0d", k), int'(c_ir), int'(!c_bz));
            if (last_hs[k]) chk($sformatf("ready_after_last%0d", k), int'(c_ir), 1);
            if (c_ov && !prev_ov[k] && exp_rise[k] >= 0) begin
               chk($sformatf("latency%0d", k), cyc, exp_rise[k]);
               exp_rise[k] = -1;
            end
            if (c_ov) begin
               if (head[k] == tail[k]) begin
                  chk($sformatf("spurious_valid%0d", k), 1, 0);
               end else begin
                  chk($sformatf("digit%0d", k), int'(c_od), int'(qd[k][head[k] % 512]));
                  chk($sformatf("last%0d", k), int'(c_ol), int'(ql[k][head[k] % 512]));
                  if (c_or) head[k]++;
               end
            end
            last_hs[k] = c_ov && c_or && c_ol;
            prev_ov[k] = c_ov;
            // Accepted on the coming rising edge; first digit WIDTH edges later.
            if (c_iv && c_ir) begin
               push(k, int'(c_id));
               exp_rise[k] = cyc + 1 + W;
            end
         end
      end
   end

   // out_ready drivers
   initial forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1)      out_ready0 = 1'($urandom);
      else if (rdy_mode == 0) out_ready0 = 1'b1;
   end
   initial forever begin
      @(posedge clk); #1;
      out_ready1 = 1'($urandom);
   end

   task automatic send(int k, int v);
      int t = 0;
      @(posedge clk); #1;
      if (k == 0) begin in_valid0 = 1'b1; in_data0 = 16'(v); end
      else        begin in_valid1 = 1'b1; in_data1 = 16'(v); end
      @(negedge clk);
      while (!(k == 0 ? in_ready0 : in_ready1) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) chk($sformatf("send_timeout%0d", k), t, 0);
      @(posedge clk); #1;
      if (k == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
   endtask

   task automatic drain(int k);
      int t = 0;
      @(negedge clk);
      while ((head[k] != tail[k] || (k == 0 ? busy0 : busy1)) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) chk($sformatf("drain_timeout%0d", k), t, 0);
   endtask

   // Second instance: no blanking, random backpressure.
   initial begin
      int t = 0;
      while (!start1 && t < 50000) begin @(posedge clk); t++; end
      send(1, 89);
      drain(1);
      repeat (8) begin
         send(1, int'($urandom_range(0, 65535)));
         drain(1);
      end
      done1 = 1;
   end

   initial begin
      int t;
      // Hand-computed pins of the reference model.
      chk("pin_0",     int'(model_enc(0, 1)),     int'(24'h100000));
      chk("pin_6765",  int'(model_enc(6765, 1)),  int'(24'h406765));
      chk("pin_65535", int'(model_enc(65535, 1)), int'(24'h565535));
      chk("pin_89_nb", int'(model_enc(89, 0)),    int'(24'h500089));
      chk("pin_233",   int'(model_enc(233, 1)),   int'(24'h300233));

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      send(0, 0);     drain(0);
      send(0, 6765);  drain(0);
      send(0, 65535); drain(0);

      // Stall on the second digit of 1597.
      send(0, 1597);
      t = 0;
      @(negedge clk);
      while (!(out_valid0 && out_ready0) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("stall_wait_timeout", t, 0);
      @(posedge clk); #2;
      rdy_mode = 2; out_ready0 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_digit_held", int'(out_digit0), 5);
      end
      @(posedge clk); #2;
      out_ready0 = 1'b1; rdy_mode = 0;
      drain(0);

      // Reset in the middle of converting 46368.
      send(0, 46368);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_immediate_valid", int'(out_valid0 | busy0 | in_ready0), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(in_ready0), 1);
      send(0, 233);
      drain(0);

      // in_valid held with changing data while busy.
      rdy_mode = 1;
      @(posedge clk); #1;
      in_valid0 = 1'b1;
      repeat (120) begin
         in_data0 = 16'($urandom);
         @(posedge clk); #1;
      end
      in_valid0 = 1'b0;
      drain(0);

      // Random terms with random backpressure, boundaries mixed in.
      start1 = 1;
      repeat (25) begin
         case ($urandom_range(0, 3))
            0:       send(0, 0);
            1:       send(0, 65535);
            default: send(0, int'($urandom_range(0, 65535)));
         endcase
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain(0);

      t = 0;
      while (!done1 && t < 20000) begin @(posedge clk); t++; end
      if (t >= 20000) chk("dut1_timeout", t, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
